// File: rtl/lfsr_gen.sv
// Galois-free Fibonacci LFSR with XNOR feedback, free-run stepping and multi-step draws.
// Optional lockup recovery from the all-ones state via `define LFSR_LOCKUP_RECOVER_EN.
module lfsr_gen #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(32'h8020_0003),
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int unsigned      DRAW_STEPS = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    input  logic             req,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid,
    output logic             busy,
    output logic             lockup
);

    localparam int unsigned CNT_W = $clog2(DRAW_STEPS + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] value_nxt, rnd_nxt, step_val;
    logic             rnd_valid_nxt, busy_nxt;
    logic             fb;

    assign fb = ~^(value & TAPS);

`ifdef LFSR_LOCKUP_RECOVER_EN
    logic lockup_nxt;
`else
    assign lockup = 1'b0;
`endif

    // Next-state and next-output decode; priority is load, recovery, draw, enable.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        value_nxt     = value;
        rnd_nxt       = rnd;
        rnd_valid_nxt = 1'b0;
        busy_nxt      = busy;
        step_val      = {value[WIDTH-2:0], fb};
`ifdef LFSR_LOCKUP_RECOVER_EN
        lockup_nxt    = 1'b0;
`endif
        if (load) begin
            value_nxt = seed;
            state_nxt = IDLE;
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
        end else begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            // Recovery replaces whatever step this edge would take.
            if (&value) begin
                step_val   = RESET_VAL;
                value_nxt  = RESET_VAL;
                lockup_nxt = 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        state_nxt = SHIFT;
                        cnt_nxt   = CNT_W'(DRAW_STEPS);
                        busy_nxt  = 1'b1;
                    end else if (enable) begin
                        value_nxt = step_val;
                    end
                end
                SHIFT: begin
                    value_nxt = step_val;
                    cnt_nxt   = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        rnd_nxt       = step_val;
                        rnd_valid_nxt = 1'b1;
                        busy_nxt      = 1'b0;
                        state_nxt     = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state     <= IDLE;
            cnt       <= '0;
            value     <= RESET_VAL;
            rnd       <= '0;
            rnd_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
            lockup    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            value     <= value_nxt;
            rnd       <= rnd_nxt;
            rnd_valid <= rnd_valid_nxt;
            busy      <= busy_nxt;
`ifdef LFSR_LOCKUP_RECOVER_EN
            lockup    <= lockup_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen (WIDTH=8, TAPS=8'hB8, DRAW_STEPS=4).
// Honours LFSR_LOCKUP_RECOVER_EN the same way the design does.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       clr_n, load, enable, req;
    logic [7:0] seed;
    logic [7:0] value, rnd;
    logic       rnd_valid, busy, lockup;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_gen #(
        .WIDTH     (8),
        .TAPS      (8'hB8),
        .RESET_VAL (8'h00),
        .DRAW_STEPS(4)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (load),
        .seed     (seed),
        .enable   (enable),
        .req      (req),
        .value    (value),
        .rnd      (rnd),
        .rnd_valid(rnd_valid),
        .busy     (busy),
        .lockup   (lockup)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr_n;
        logic       load;
        logic       enable;
        logic       req;
        logic [7:0] seed;
        logic [7:0] exp_value;
        logic       exp_busy;
        logic       exp_rv;
    } vec_t;

    vec_t tbl[12];

    // Behavioural model state
    int m_value, m_rnd, m_left;
    bit m_rv, m_busy, m_lock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic r, input logic [7:0] s);
        clr_n = c; load = l; enable = e; req = r; seed = s;
    endtask

    // Next LFSR state by counting tapped ones: even count -> feed a 1.
    function automatic int lfsr_next(input int v);
        int ones = 0;
        for (int i = 0; i < 8; i++)
            if (((v >> i) & 1) == 1 && ((8'hB8 >> i) & 1) == 1) ones++;
        return ((v << 1) & 255) | ((ones % 2 == 0) ? 1 : 0);
    endfunction

    task automatic model_step();
        bit recover;
        int nv;
`ifdef LFSR_LOCKUP_RECOVER_EN
        recover = (m_value == 255);
`else
        recover = 1'b0;
`endif
        m_rv   = 1'b0;
        m_lock = 1'b0;
        if (!clr_n) begin
            m_value = 0; m_rnd = 0; m_left = 0; m_busy = 1'b0;
        end else if (load) begin
            m_value = int'(seed); m_left = 0; m_busy = 1'b0;
        end else begin
            m_lock = recover;
            nv = recover ? 0 : lfsr_next(m_value);
            if (m_left > 0) begin
                m_value = nv;
                m_left--;
                if (m_left == 0) begin
                    m_rnd  = m_value;
                    m_rv   = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (req) begin
                m_left = 4;
                m_busy = 1'b1;
                if (recover) m_value = 0;
            end else if (enable || recover) begin
                m_value = nv;
            end
        end
    endtask

    initial begin
        int  distinct;
        bit  seen[256];
        bit  hit_ff;
        int  rv_count;

        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Directed vector table: reset, free-run, load, priority cases
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h0F, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h1E, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hB5, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 8'h33, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].clr_n, tbl[i].load, tbl[i].enable, tbl[i].req, tbl[i].seed);
            tick();
            chk($sformatf("tbl%0d_value", i), value, tbl[i].exp_value);
            chk($sformatf("tbl%0d_busy", i), 8'(busy), 8'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_rnd_valid", i), 8'(rnd_valid), 8'(tbl[i].exp_rv));
        end
        chk("reset_rnd", rnd, 8'h00);
        chk("reset_lockup", 8'(lockup), 8'h00);

        // Full period from reset
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        distinct = 0;
        hit_ff   = 1'b0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (value == 8'hFF) hit_ff = 1'b1;
            if (!seen[value]) begin
                seen[value] = 1'b1;
                distinct++;
            end
        end
        chk("period_final_value", value, 8'h00);
        chk("period_distinct", 8'(distinct), 8'd255);
        chk("period_no_ff", 8'(hit_ff), 8'h00);

        // Draw timing, with a dropped second request while busy
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        rv_count = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 1'b0, (k == 0 || k == 2), 8'h00);
            tick();
            chk($sformatf("draw_busy_e%0d", k), 8'(busy), 8'(k < 4));
            chk($sformatf("draw_rv_e%0d", k), 8'(rnd_valid), 8'(k == 4));
            if (rnd_valid) rv_count++;
            if (k == 4) chk("draw_rnd", rnd, 8'h0F);
        end
        chk("draw_rv_count", 8'(rv_count), 8'd1);
        chk("draw_rnd_hold", rnd, 8'h0F);

        // Load aborts a draw; rnd holds
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
        tick();
        chk("abort_value", value, 8'h5A);
        chk("abort_busy", 8'(busy), 8'h00);
        chk("abort_rnd", rnd, 8'h0F);
        rv_count = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 6; k++) begin
            if (rnd_valid) rv_count++;
            tick();
        end
        chk("abort_no_rv", 8'(rv_count), 8'd0);
        chk("abort_value_hold", value, 8'h5A);

        // Reset mid-draw
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hC3);
        tick();
        chk("clr_value", value, 8'h00);
        chk("clr_rnd", rnd, 8'h00);
        chk("clr_busy", 8'(busy), 8'h00);
        chk("clr_rv", 8'(rnd_valid), 8'h00);
        chk("clr_lockup", 8'(lockup), 8'h00);

        // All-ones handling
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        tick();
        chk("ff_loaded", value, 8'hFF);
        chk("ff_lockup_at_load", 8'(lockup), 8'h00);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
`ifdef LFSR_LOCKUP_RECOVER_EN
        chk("recover_value", value, 8'h00);
        chk("recover_lockup", 8'(lockup), 8'h01);
        tick();
        chk("recover_lockup_pulse", 8'(lockup), 8'h00);
        chk("recover_then_shift", value, 8'h01);
`else
        chk("stuck_value", value, 8'hFF);
        chk("stuck_lockup", 8'(lockup), 8'h00);
        tick();
        chk("stuck_value2", value, 8'hFF);
        chk("stuck_lockup2", 8'(lockup), 8'h00);
`endif

        // Randomized run against the behavioural model
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom));
            @(posedge clk);
            model_step();
            #1;
            chk("rand_value", value, 8'(m_value));
            chk("rand_rnd", rnd, 8'(m_rnd));
            chk("rand_rv", 8'(rnd_valid), 8'(m_rv));
            chk("rand_busy", 8'(busy), 8'(m_busy));
            chk("rand_lockup", 8'(lockup), 8'(m_lock));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
